fhe_op_dispatcher: RTL and testbench

Upstream issue stage for the FHE cpu core. Buffers a queue of `operation` records (CT-CT ADD, CT-PT ADD, CT-PT MUL, CT-CT MUL) and presents them to the cpu one at a time. Each op is driven for exactly one cycle, then NO_OP until cpu `done_out`, then one writeback-settle cycle. Serialising issue this way removes register-file hazards. The block also adds a watchdog, a sticky error flag and issue/retire counters.

---
 rtl/fhe_op_dispatcher_pkg.sv | 35 +++
 rtl/fhe_op_dispatcher_op_fifo.sv | 50 +++++
 rtl/fhe_op_dispatcher.sv | 119 +++++++++++
 tb/tb_fhe_op_dispatcher.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_op_dispatcher_pkg.sv
// Shared types for the FHE op dispatcher: operation record, op modes and FSM states.
package fhe_op_dispatcher_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned IDX_W  = 4;

    // NO_OP must stay at zero so an all-zero operation is the idle op.
    typedef enum logic [MODE_W-1:0] {
        NO_OP        = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_PT_MUL = 3'd3,
        OP_CT_CT_MUL = 3'd4
    } op_mode_e;

    typedef struct packed {
        op_mode_e         mode;
        logic [IDX_W-1:0] src0_a;
        logic [IDX_W-1:0] src0_b;
        logic [IDX_W-1:0] src1_a;
        logic [IDX_W-1:0] src1_b;
        logic [IDX_W-1:0] dst_a;
        logic [IDX_W-1:0] dst_b;
    } operation;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE
    } disp_state_e;

    localparam operation NOP_OP = operation'('0);

endpackage

// File: rtl/fhe_op_dispatcher_op_fifo.sv
// Synchronous FIFO of operation records; full/empty derive from the stored level.
module op_fifo
    import fhe_op_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  operation                     push_data,
    input  logic                         pop,
    output operation                     pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    operation         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fhe_op_dispatcher.sv
// Serialising issue stage for the FHE cpu: one op per ISSUE, then wait for done and settle.
module fhe_op_dispatcher
    import fhe_op_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  operation                     in_op,
    output operation                     cpu_op,
    input  logic                         cpu_done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         err_timeout,
    input  logic                         err_clr,
    output logic [CNT_W-1:0]             issued_cnt,
    output logic [CNT_W-1:0]             retired_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    disp_state_e       state;
    disp_state_e       state_nxt;
    operation          cpu_op_nxt;
    operation          head;
    logic [CNT_W-1:0]  issued_nxt;
    logic [CNT_W-1:0]  retired_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              err_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // NO_OP records are handshaken but never stored.
    assign in_ready = reset_n && !full;
    assign push     = in_valid && in_ready && (in_op.mode != NO_OP);
    assign busy     = (state != ST_IDLE) || !empty;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_op),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nxt   = state;
        cpu_op_nxt  = NOP_OP;
        issued_nxt  = issued_cnt;
        retired_nxt = retired_cnt;
        wait_nxt    = wait_cnt;
        err_nxt     = err_clr ? 1'b0 : err_timeout;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cpu_op_nxt = head;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issued_nxt = issued_cnt + CNT_W'(1);
                wait_nxt   = '0;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still retires the op.
                if (cpu_done) begin
                    retired_nxt = retired_cnt + CNT_W'(1);
                    state_nxt   = ST_SETTLE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_SETTLE;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_SETTLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cpu_op      <= NOP_OP;
            issued_cnt  <= '0;
            retired_cnt <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cpu_op      <= cpu_op_nxt;
            issued_cnt  <= issued_nxt;
            retired_cnt <= retired_nxt;
            wait_cnt    <= wait_nxt;
            err_timeout <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fhe_op_dispatcher.sv
// Directed bench for fhe_op_dispatcher with an issue-order scoreboard and a simple cpu responder.
module tb_fhe_op_dispatcher;
    import fhe_op_dispatcher_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    operation         in_op;
    operation         cpu_op;
    logic             cpu_done;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic             err_timeout;
    logic             err_clr;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] retired_cnt;

    logic man_done;
    logic auto_done;
    logic auto_en;
    int   auto_dly;
    assign cpu_done = man_done | auto_done;

    int       n_cmp;
    int       n_err;
    int       cyc;
    int       exp_issued;
    int       exp_retired;
    int       obs_rd;
    operation exp_q[$];
    operation obs_q[$];
    int       obs_cyc[$];

    fhe_op_dispatcher #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .cpu_op      (cpu_op),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .issued_cnt  (issued_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle a real op sits on cpu_op is logged; a held op shows up twice.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && cpu_op.mode != NO_OP) begin
            obs_q.push_back(cpu_op);
            obs_cyc.push_back(cyc);
        end
    end

    // Responder: pulse done auto_dly cycles after an op is issued.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (auto_en && cpu_op.mode != NO_OP) begin
                repeat (auto_dly) begin @(posedge clk); #1; end
                auto_done = 1'b1;
                @(posedge clk); #1;
                auto_done = 1'b0;
            end
        end
    end

    function automatic operation mk(op_mode_e m, int a, int b, int c, int d, int e, int f);
        operation o;
        o.mode   = m;
        o.src0_a = IDX_W'(a);
        o.src0_b = IDX_W'(b);
        o.src1_a = IDX_W'(c);
        o.src1_b = IDX_W'(d);
        o.dst_a  = IDX_W'(e);
        o.dst_b  = IDX_W'(f);
        return o;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_op(input string tag, input operation obs, input operation expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input operation op);
        int budget = 50;
        in_valid = 1'b1;
        in_op    = op;
        while (in_ready !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        check_val("push_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        if (op.mode != NO_OP) exp_q.push_back(op);
    endtask

    task automatic wait_idle(input int budget);
        while (busy !== 1'b0 && budget > 0) begin
            step();
            budget--;
        end
        check_val("idle_reached", 32'(busy), 0);
    endtask

    task automatic wait_issue(input int budget);
        while (cpu_op.mode == NO_OP && budget > 0) begin
            step();
            budget--;
        end
        check_val("issue_seen", 32'(cpu_op.mode != NO_OP), 1);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_issued"}, 32'(issued_cnt), exp_issued);
        check_val({tag, "_retired"}, 32'(retired_cnt), exp_retired);
    endtask

    // Issued ops must match the scoreboard in order, each exactly once, at least 4 cycles apart.
    task automatic drain(input string tag);
        check_val({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            check_op({tag, "_op"}, obs_q[obs_rd], exp_q[0]);
            if (obs_rd > 0)
                check_val({tag, "_gap"}, 32'(obs_cyc[obs_rd] - obs_cyc[obs_rd-1] >= 4), 1);
            void'(exp_q.pop_front());
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    initial begin
        operation a;
        operation b;
        n_cmp = 0; n_err = 0; exp_issued = 0; exp_retired = 0; obs_rd = 0;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_op    = mk(OP_CT_CT_ADD, 9, 9, 9, 9, 9, 9);
        man_done = 1'b0;
        auto_en  = 1'b0;
        auto_dly = 1;
        err_clr  = 1'b0;

        // Reset state with a producer already offering an op
        repeat (3) step();
        check_val("rst_in_ready", 32'(in_ready), 0);
        check_op("rst_cpu_op", cpu_op, NOP_OP);
        check_counts("rst");
        check_val("rst_level", 32'(fifo_level), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_err", 32'(err_timeout), 0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();

        // Single op: latency, one-cycle presentation, delayed done
        a = mk(OP_CT_CT_ADD, 0, 1, 2, 3, 5, 6);
        push(a);
        step();
        check_op("t1_latency", cpu_op, a);
        step();
        check_op("t1_one_cycle", cpu_op, NOP_OP);
        exp_issued++;
        check_val("t1_issued", 32'(issued_cnt), exp_issued);
        step(); step();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        exp_retired++;
        check_val("t1_retired", 32'(retired_cnt), exp_retired);
        check_val("t1_settle_busy", 32'(busy), 1);
        step();
        check_val("t1_idle_busy", 32'(busy), 0);
        drain("t1");

        // Burst until full while the cpu holds off done
        for (int i = 0; i < 9; i++) begin
            b = mk(op_mode_e'(3'(1 + i % 4)), i, i + 1, i + 2, i + 3, i + 4, i + 5);
            check_val("t2_ready", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_op    = b;
            exp_q.push_back(b);
            step();
        end
        in_op = mk(OP_CT_CT_MUL, 15, 15, 15, 15, 15, 15);
        check_val("t2_full_ready", 32'(in_ready), 0);
        check_val("t2_full_level", 32'(fifo_level), DEPTH);
        step(); step();
        check_val("t2_stall_ready", 32'(in_ready), 0);
        check_val("t2_stall_level", 32'(fifo_level), DEPTH);
        in_valid = 1'b0;
        auto_en  = 1'b1;
        auto_dly = 1;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        wait_idle(300);
        exp_issued  += 9;
        exp_retired += 9;
        check_counts("t2");
        drain("t2");

        // NO_OP is handshaken but never stored or issued
        push(mk(NO_OP, 1, 2, 3, 4, 5, 6));
        check_val("t3_nop_level", 32'(fifo_level), 0);
        check_val("t3_nop_busy", 32'(busy), 0);
        a = mk(OP_CT_PT_MUL, 7, 8, 9, 10, 11, 12);
        push(a);
        check_val("t3_level", 32'(fifo_level), 1);
        wait_idle(50);
        exp_issued++;
        exp_retired++;
        check_counts("t3");
        drain("t3");

        // Watchdog: 16 WAIT cycles without done, then clear and a coincident set
        auto_en = 1'b0;
        push(mk(OP_CT_CT_ADD, 1, 1, 2, 2, 3, 3));
        push(mk(OP_CT_PT_ADD, 4, 4, 5, 5, 6, 6));
        wait_issue(10);
        repeat (TMO) step();
        check_val("t4_err_before", 32'(err_timeout), 0);
        step();
        check_val("t4_err_set", 32'(err_timeout), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("t4_err_clr", 32'(err_timeout), 0);
        wait_issue(10);
        repeat (TMO) step();
        check_val("t4_err_before2", 32'(err_timeout), 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("t4_set_beats_clr", 32'(err_timeout), 1);
        wait_idle(10);
        exp_issued += 2;
        check_counts("t4");
        drain("t4");

        // Stray done while idle and during ISSUE is ignored
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        check_counts("t5_idle");
        check_val("t5_idle_busy", 32'(busy), 0);
        a = mk(OP_CT_CT_MUL, 2, 3, 4, 5, 6, 7);
        push(a);
        step();
        check_op("t5_issue", cpu_op, a);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        exp_issued++;
        check_counts("t5_issue");
        step(); step();
        check_val("t5_still_wait", 32'(busy), 1);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        exp_retired++;
        check_counts("t5_done");
        wait_idle(10);
        drain("t5");

        // Reset during WAIT with ops queued abandons everything
        for (int i = 0; i < 4; i++) push(mk(OP_CT_PT_ADD, i, 0, i, 1, i, 2));
        step(); step();
        check_val("t6_level", 32'(fifo_level), 3);
        check_val("t6_busy", 32'(busy), 1);
        reset_n = 1'b0;
        step();
        check_val("t6_rst_level", 32'(fifo_level), 0);
        check_val("t6_rst_busy", 32'(busy), 0);
        check_op("t6_rst_cpu_op", cpu_op, NOP_OP);
        check_val("t6_rst_err", 32'(err_timeout), 0);
        check_val("t6_rst_ready", 32'(in_ready), 0);
        exp_issued  = 0;
        exp_retired = 0;
        check_counts("t6_rst");
        reset_n = 1'b1;
        step();
        // Only the first op reached the cpu; the queued ones were lost in reset.
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        drain("t6");

        // Normal operation resumes after reset
        auto_en = 1'b1;
        push(mk(OP_CT_CT_ADD, 3, 2, 1, 0, 6, 5));
        wait_idle(50);
        exp_issued++;
        exp_retired++;
        check_counts("t7");
        drain("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
